// File: rtl/sys_rst_sequencer.sv
// Power-up/reset sequencer: PLL reset, lock qualification, staged release of NUM_CH domain resets.
// Optional macro SYS_RST_LOCK_TIMEOUT_EN: retry the PLL reset if LOCK_WAIT exceeds LOCK_TIMEOUT cycles.
module sys_rst_sequencer #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned INIT_DELAY     = 2500000,
    parameter int unsigned LOCK_FILTER    = 16,
    parameter int unsigned STAGE_DELAY    = 1024,
    parameter int unsigned PLL_RST_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_rst_n,
    input  logic              pll_locked,
    output logic              pll_areset,
    output logic [NUM_CH-1:0] sys_rst_n,
    output logic              seq_done,
    output logic [7:0]        lock_lost_cnt,
    output logic [2:0]        state_o
);

    localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int unsigned STG_W  = $clog2(NUM_CH + 1);

    // Every delay is counted as 0..P-1 in the shared counter, so P-1 must fit in CNT_W bits.
    if (NUM_CH < 1 || NUM_CH > 16 || CNT_W < 1 || INIT_DELAY < 1 || LOCK_FILTER < 1 ||
        STAGE_DELAY < 1 || PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
        ((INIT_DELAY - 1) >> CNT_W) != 0 || ((STAGE_DELAY - 1) >> CNT_W) != 0 ||
        ((PLL_RST_CYCLES - 1) >> CNT_W) != 0 || ((LOCK_TIMEOUT - 1) >> CNT_W) != 0) begin : g_param_err
        $error("sys_rst_sequencer: parameter out of range or does not fit in CNT_W");
    end

    typedef enum logic [2:0] {
        INIT_WAIT = 3'd0,
        LOCK_WAIT = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        PLL_RST   = 3'd4,
        HOLD      = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic [STG_W-1:0]    stg_q, stg_d;
    logic                lock_lo_q;
    logic                ext_meta, ext_s;
    logic                lock_meta, lock_s;
    logic                lost_c;
    logic                lost_inc;
    logic                pll_areset_d;
    logic                seq_done_d;
    logic [NUM_CH-1:0]   sys_rst_n_d;

    assign state_o = state_q;

    // Two-flop synchronisers for the asynchronous button and lock inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_meta  <= 1'b0;
            ext_s     <= 1'b0;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            ext_meta  <= ext_rst_n;
            ext_s     <= ext_meta;
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        filt_d   = '0;
        stg_d    = stg_q;
        lost_inc = 1'b0;
        // Lock loss: synced lock low on two consecutive samples while releasing or running
        lost_c   = lock_lo_q && !lock_s && (state_q == RELEASE || state_q == RUN);

        case (state_q)
            INIT_WAIT: begin
                if (cnt_q == CNT_W'(INIT_DELAY - 1)) state_d = LOCK_WAIT;
            end
            LOCK_WAIT: begin
                filt_d = lock_s ? filt_q + FILT_W'(1) : '0;
                if (!ext_s)                                  state_d = HOLD;
                else if (filt_d == FILT_W'(LOCK_FILTER))     state_d = RELEASE;
`ifdef SYS_RST_LOCK_TIMEOUT_EN
                else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1))  state_d = PLL_RST;
`endif
            end
            RELEASE: begin
                if (lost_c)                         state_d = PLL_RST;
                else if (!ext_s)                    state_d = HOLD;
                else if (stg_q == STG_W'(NUM_CH))   state_d = RUN;
                else if (stg_q == '0 || cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                    stg_d = stg_q + STG_W'(1);
                    cnt_d = '0;
                end
            end
            RUN: begin
                if (lost_c) begin
                    state_d  = PLL_RST;
                    lost_inc = 1'b1;
                end else if (!ext_s) begin
                    state_d  = HOLD;
                end
            end
            PLL_RST: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = LOCK_WAIT;
            end
            HOLD: begin
                if (ext_s) state_d = RELEASE;
            end
            default: state_d = INIT_WAIT;
        endcase

        if (state_d != state_q) begin
            cnt_d  = '0;
            filt_d = '0;
            stg_d  = '0;
        end

        pll_areset_d = (state_d == INIT_WAIT) || (state_d == PLL_RST);
        seq_done_d   = (state_d == RUN);
        for (int i = 0; i < NUM_CH; i++) begin
            sys_rst_n_d[i] = (state_d == RUN) || (STG_W'(i) < stg_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= INIT_WAIT;
            cnt_q         <= '0;
            filt_q        <= '0;
            stg_q         <= '0;
            lock_lo_q     <= 1'b0;
            pll_areset    <= 1'b1;
            sys_rst_n     <= '0;
            seq_done      <= 1'b0;
            lock_lost_cnt <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            stg_q      <= stg_d;
            lock_lo_q  <= !lock_s;
            pll_areset <= pll_areset_d;
            sys_rst_n  <= sys_rst_n_d;
            seq_done   <= seq_done_d;
            if (lost_inc && lock_lost_cnt != 8'hFF) lock_lost_cnt <= lock_lost_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_sys_rst_sequencer.sv
// Bench for sys_rst_sequencer: phase/elapsed-time reference model, directed scenarios and random stimulus.
`timescale 1ns/1ps
module tb_sys_rst_sequencer;

    localparam int unsigned NCH    = 3;
    localparam int unsigned INIT_D = 100;
    localparam int unsigned LFILT  = 4;
    localparam int unsigned SDLY   = 8;
    localparam int unsigned PRC    = 10;
    localparam int unsigned LTMO   = 50;

    logic           clk = 1'b0;
    logic           rst;
    logic           ext_rst_n;
    logic           pll_locked;
    logic           pll_areset;
    logic [NCH-1:0] sys_rst_n;
    logic           seq_done;
    logic [7:0]     lock_lost_cnt;
    logic [2:0]     state_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    sys_rst_sequencer #(
        .NUM_CH(NCH), .CNT_W(16), .INIT_DELAY(INIT_D), .LOCK_FILTER(LFILT),
        .STAGE_DELAY(SDLY), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTMO)
    ) dut (
        .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .pll_locked(pll_locked),
        .pll_areset(pll_areset), .sys_rst_n(sys_rst_n), .seq_done(seq_done),
        .lock_lost_cnt(lock_lost_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference model: current phase, cycles elapsed in it, and a few history bits
    int m_ph, m_t, m_ones, m_lost;
    bit m_e1, m_e2, m_l1, m_l2, m_prev_low;

    function automatic logic [NCH-1:0] exp_rst(input int ph, input int t);
        int n;
        if (ph == 3) return '1;
        if (ph != 2 || t < 1) return '0;
        n = 1 + (t - 1) / int'(SDLY);
        if (n > int'(NCH)) n = int'(NCH);
        return NCH'((1 << n) - 1);
    endfunction

    initial forever begin
        bit es, ls, lost;
        int nx;
        @(posedge clk);
        if (rst) begin
            m_ph = 0; m_t = 0; m_ones = 0; m_lost = 0;
            m_e1 = 0; m_e2 = 0; m_l1 = 0; m_l2 = 0; m_prev_low = 0;
        end else begin
            es = m_e2;
            ls = m_l2;
            m_e2 = m_e1; m_e1 = ext_rst_n;
            m_l2 = m_l1; m_l1 = pll_locked;
            lost = (m_ph == 2 || m_ph == 3) && !ls && m_prev_low;
            m_prev_low = !ls;
            m_t++;
            nx = m_ph;
            case (m_ph)
                0: if (m_t == int'(INIT_D)) nx = 1;
                1: begin
                    if (!es) nx = 5;
                    else begin
                        m_ones = ls ? m_ones + 1 : 0;
                        if (m_ones >= int'(LFILT)) nx = 2;
`ifdef SYS_RST_LOCK_TIMEOUT_EN
                        else if (m_t == int'(LTMO)) nx = 4;
`endif
                    end
                end
                2: begin
                    if (lost) nx = 4;
                    else if (!es) nx = 5;
                    else if (m_t == 2 + (int'(NCH) - 1) * int'(SDLY)) nx = 3;
                end
                3: begin
                    if (lost) begin
                        nx = 4;
                        if (m_lost < 255) m_lost++;
                    end else if (!es) nx = 5;
                end
                4: if (m_t == int'(PRC)) nx = 1;
                5: if (es) nx = 2;
                default: nx = 0;
            endcase
            if (nx != m_ph) begin
                m_ph = nx; m_t = 0; m_ones = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model state_o", 32'(state_o), 32'(m_ph));
            check("model pll_areset", 32'(pll_areset), 32'(m_ph == 0 || m_ph == 4));
            check("model sys_rst_n", 32'(sys_rst_n), 32'(exp_rst(m_ph, m_t)));
            check("model seq_done", 32'(seq_done), 32'(m_ph == 3));
            check("model lock_lost_cnt", 32'(lock_lost_cnt), 32'(m_lost));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (state_o !== s && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(state_o), 32'(s));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int r, lock_lo, ext_lo, rst_hi;
        rst = 1'b1; ext_rst_n = 1'b1; pll_locked = 1'b1;
        tick(1);
        chk_en = 1'b1;
        tick(4);
        check("reset state_o", 32'(state_o), 32'd0);
        check("reset pll_areset", 32'(pll_areset), 32'd1);
        check("reset sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("reset seq_done", 32'(seq_done), 32'd0);
        check("reset lock_lost_cnt", 32'(lock_lost_cnt), 32'd0);

        // Power-up sequence
        rst = 1'b0;
        tick(99);
        check("init pll_areset held", 32'(pll_areset), 32'd1);
        tick(1);
        check("init pll_areset falls", 32'(pll_areset), 32'd0);
        check("init enters LOCK_WAIT", 32'(state_o), 32'd1);
        tick(4);
        check("lock qualified", 32'(state_o), 32'd2);
        check("release start", 32'(sys_rst_n), 32'd0);
        tick(1);
        check("release 001", 32'(sys_rst_n), 32'b001);
        tick(8);
        check("release 011", 32'(sys_rst_n), 32'b011);
        tick(8);
        check("release 111", 32'(sys_rst_n), 32'b111);
        check("seq_done before RUN", 32'(seq_done), 32'd0);
        tick(1);
        check("seq_done in RUN", 32'(seq_done), 32'd1);
        check("RUN state", 32'(state_o), 32'd3);

        // Lock loss in RUN
        tick(5);
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        tick(1);
        check("loss PLL_RST", 32'(state_o), 32'd4);
        check("loss sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("loss pll_areset", 32'(pll_areset), 32'd1);
        check("loss count 1", 32'(lock_lost_cnt), 32'd1);
        tick(9);
        check("pll pulse last cycle", 32'(pll_areset), 32'd1);
        tick(1);
        check("pll pulse ended", 32'(pll_areset), 32'd0);
        wait_state(3'd3, 200, "relock RUN");

        // Push-button reset in RUN
        tick(3);
        ext_rst_n = 1'b0;
        tick(3);
        check("button HOLD", 32'(state_o), 32'd5);
        check("button sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("button pll_areset", 32'(pll_areset), 32'd0);
        tick(17);
        ext_rst_n = 1'b1;
        wait_state(3'd2, 10, "button RELEASE");
        tick(1);
        check("button 001", 32'(sys_rst_n), 32'b001);
        tick(8);
        check("button 011", 32'(sys_rst_n), 32'b011);
        tick(8);
        check("button 111", 32'(sys_rst_n), 32'b111);
        tick(1);
        check("button RUN", 32'(state_o), 32'd3);

        // Simultaneous lock loss and button: lock loss wins
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        ext_rst_n = 1'b0;
        tick(3);
        check("priority PLL_RST", 32'(state_o), 32'd4);
        check("priority count 2", 32'(lock_lost_cnt), 32'd2);
        pll_locked = 1'b1;
        tick(20);
        check("button after pulse HOLD", 32'(state_o), 32'd5);
        ext_rst_n = 1'b1;
        wait_state(3'd3, 200, "priority recover RUN");

        // Mid-sequence rst, then lock chattering 1,1,1,0 in LOCK_WAIT
        rst = 1'b1;
        tick(2);
        check("rst clears count", 32'(lock_lost_cnt), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            pll_locked = (i % 4 != 3);
            tick(1);
        end
        check("chatter stays LOCK_WAIT", 32'(state_o), 32'd1);
        pll_locked = 1'b1;
        tick(3);
        check("filter not yet", 32'(state_o), 32'd1);
        tick(1);
        check("filter qualified", 32'(state_o), 32'd2);
        wait_state(3'd3, 200, "chatter RUN");

        // Saturation of the lock-loss counter
        for (int k = 0; k < 260; k++) begin
            wait_state(3'd3, 200, "sat RUN");
            pll_locked = 1'b0;
            tick(3);
            pll_locked = 1'b1;
            tick(2);
        end
        tick(1);
        check("lock_lost_cnt saturates", 32'(lock_lost_cnt), 32'd255);

        // Random stimulus
        lock_lo = 0; ext_lo = 0; rst_hi = 0;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if (lock_lo == 0 && r < 6) lock_lo = int'($urandom_range(1, 6));
            if (ext_lo == 0 && r >= 6 && r < 10) ext_lo = int'($urandom_range(1, 30));
            if (rst_hi == 0 && r == 10) rst_hi = int'($urandom_range(1, 3));
            pll_locked = (lock_lo == 0);
            ext_rst_n  = (ext_lo == 0);
            rst        = (rst_hi != 0);
            tick(1);
            if (lock_lo > 0) lock_lo--;
            if (ext_lo > 0) ext_lo--;
            if (rst_hi > 0) rst_hi--;
        end

        // PLL never locks
        rst = 1'b1; ext_rst_n = 1'b1; pll_locked = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(100);
        check("nolock LOCK_WAIT", 32'(state_o), 32'd1);
`ifdef SYS_RST_LOCK_TIMEOUT_EN
        tick(49);
        check("timeout not yet", 32'(state_o), 32'd1);
        tick(1);
        check("timeout PLL_RST", 32'(state_o), 32'd4);
        tick(10);
        check("timeout back LOCK_WAIT", 32'(state_o), 32'd1);
        tick(50);
        check("timeout repeats", 32'(state_o), 32'd4);
`else
        tick(500);
        check("nolock stays LOCK_WAIT", 32'(state_o), 32'd1);
`endif
        check("nolock count 0", 32'(lock_lost_cnt), 32'd0);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
